// File: rtl/md5_pkg.sv
// Shared types and constants for the MD5 step sequencer: controller states,
// per-round rotate amounts, initial chaining values and the step count.
package md5_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_ACC  = 3'd3,
    ST_OUT  = 3'd4
  } state_t;

  localparam int STEPS = 64;

  // SHIFT_TAB[round][step % 4]; rows are listed round 3 first, columns col 3 first.
  localparam logic [3:0][3:0][4:0] SHIFT_TAB = {
    {5'd21, 5'd15, 5'd10, 5'd6},
    {5'd23, 5'd16, 5'd11, 5'd4},
    {5'd20, 5'd14, 5'd9,  5'd5},
    {5'd22, 5'd17, 5'd12, 5'd7}
  };

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hEFCDAB89;
  localparam logic [31:0] IV_C = 32'h98BADCFE;
  localparam logic [31:0] IV_D = 32'h10325476;

endpackage

// File: rtl/md5_step_decode.sv
// Combinational decode of an MD5 step index into round, message-word index
// and left-rotate amount. All index arithmetic is modulo 16 on the low nibble.
module md5_step_decode (
  input  logic [5:0] step_idx_i,
  output logic [1:0] round_o,
  output logic [3:0] g_idx_o,
  output logic [4:0] shift_o
);
  import md5_pkg::*;

  logic [3:0] w_i4;
  logic [3:0] w_g;

  assign w_i4    = step_idx_i[3:0];
  assign round_o = step_idx_i[5:4];

  // 5i, 3i and 7i are built from shifts and adds of the low nibble.
  always_comb begin
    w_g = w_i4;
    case (step_idx_i[5:4])
      2'd0: w_g = w_i4;
      2'd1: w_g = {w_i4[1:0], 2'b00} + w_i4 + 4'd1;
      2'd2: w_g = {w_i4[2:0], 1'b0} + w_i4 + 4'd5;
      2'd3: w_g = {w_i4[0], 3'b000} - w_i4;
      default: w_g = w_i4;
    endcase
  end

  assign g_idx_o = w_g;
  assign shift_o = SHIFT_TAB[step_idx_i[5:4]][step_idx_i[1:0]];

endmodule

// File: rtl/md5_step_ctrl.sv
// Sequencing controller for the single-step MD5 datapath: block handshake,
// 64-step run, chaining load/accumulate strobes and digest handshake.
// Define MD5_BLKCNT_EN to add the blk_cnt_o processed-block counter.
module md5_step_ctrl #(
  parameter int STEPS = 64
`ifdef MD5_BLKCNT_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             blk_valid_i,
  input  logic             blk_last_i,
  output logic             blk_ready_o,
  output logic             iv_load_o,
  output logic             first_o,
  output logic             step_en_o,
  output logic [5:0]       step_idx_o,
  output logic [1:0]       round_o,
  output logic [3:0]       g_idx_o,
  output logic [4:0]       shift_o,
  output logic             acc_o,
  output logic             digest_valid_o,
  input  logic             digest_ready_i,
`ifdef MD5_BLKCNT_EN
  output logic [CNT_W-1:0] blk_cnt_o,
`endif
  output logic             busy_o
);
  import md5_pkg::*;

  localparam logic [5:0] LAST_STEP = 6'(STEPS - 1);

  state_t     r_state;
  logic [5:0] r_step;
  logic       r_first_q;
  logic       r_last_q;
  logic       r_ready;
  logic       r_iv_load;
  logic       r_first;
  logic       r_step_en;
  logic       r_acc;
  logic       r_dvalid;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits for ready, and ready is only offered in IDLE
  // (blocks) or implied by OUT (digest), so nothing is ever queued.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_step    <= 6'd0;
      r_first_q <= 1'b1;
      r_last_q  <= 1'b0;
      r_ready   <= 1'b1;
      r_iv_load <= 1'b0;
      r_first   <= 1'b0;
      r_step_en <= 1'b0;
      r_acc     <= 1'b0;
      r_dvalid  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (blk_valid_i && r_ready) begin
            r_state   <= ST_LOAD;
            r_last_q  <= blk_last_i;
            r_ready   <= 1'b0;
            r_iv_load <= 1'b1;
            r_first   <= r_first_q;
          end
        end
        ST_LOAD: begin
          r_state   <= ST_RUN;
          r_iv_load <= 1'b0;
          r_first   <= 1'b0;
          r_step_en <= 1'b1;
        end
        ST_RUN: begin
          r_step <= r_step + 6'd1;
          if (r_step == LAST_STEP) begin
            r_state   <= ST_ACC;
            r_step_en <= 1'b0;
            r_acc     <= 1'b1;
          end
        end
        ST_ACC: begin
          r_acc     <= 1'b0;
          r_first_q <= 1'b0;
          if (r_last_q) begin
            r_state  <= ST_OUT;
            r_dvalid <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end
        end
        ST_OUT: begin
          if (digest_ready_i) begin
            r_state   <= ST_IDLE;
            r_dvalid  <= 1'b0;
            r_ready   <= 1'b1;
            r_first_q <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_step    <= 6'd0;
          r_ready   <= 1'b1;
          r_iv_load <= 1'b0;
          r_first   <= 1'b0;
          r_step_en <= 1'b0;
          r_acc     <= 1'b0;
          r_dvalid  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MD5_BLKCNT_EN
  logic [CNT_W-1:0] r_blk_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_blk_cnt <= '0;
    end else if (r_state == ST_OUT && digest_ready_i) begin
      r_blk_cnt <= '0;
    end else if (r_state == ST_ACC) begin
      r_blk_cnt <= r_blk_cnt + 1'b1;
    end
  end

  assign blk_cnt_o = r_blk_cnt;
`endif

  md5_step_decode u_decode (
    .step_idx_i (r_step),
    .round_o    (round_o),
    .g_idx_o    (g_idx_o),
    .shift_o    (shift_o)
  );

  assign step_idx_o     = r_step;
  assign blk_ready_o    = r_ready;
  assign iv_load_o      = r_iv_load;
  assign first_o        = r_first;
  assign step_en_o      = r_step_en;
  assign acc_o          = r_acc;
  assign digest_valid_o = r_dvalid;
  assign busy_o         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_md5_step_ctrl.sv
// Self-checking bench for md5_step_ctrl: decode table, block/digest timing,
// chained messages, mid-run reset and ignored valid while busy.
module tb_md5_step_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        blk_valid_i;
  logic        blk_last_i;
  logic        blk_ready_o;
  logic        iv_load_o;
  logic        first_o;
  logic        step_en_o;
  logic [5:0]  step_idx_o;
  logic [1:0]  round_o;
  logic [3:0]  g_idx_o;
  logic [4:0]  shift_o;
  logic        acc_o;
  logic        digest_valid_o;
  logic        digest_ready_i;
  logic        busy_o;
`ifdef MD5_BLKCNT_EN
  logic [15:0] blk_cnt_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  // {step, round, g, shift}
  logic [16:0] exp_q[$];
  logic [16:0] obs[64];

  typedef struct {
    int step;
    int rnd;
    int g;
    int sh;
  } dec_vec_t;

  dec_vec_t dtab[9];
  int sh_tab[16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

  md5_step_ctrl dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .blk_valid_i    (blk_valid_i),
    .blk_last_i     (blk_last_i),
    .blk_ready_o    (blk_ready_o),
    .iv_load_o      (iv_load_o),
    .first_o        (first_o),
    .step_en_o      (step_en_o),
    .step_idx_o     (step_idx_o),
    .round_o        (round_o),
    .g_idx_o        (g_idx_o),
    .shift_o        (shift_o),
    .acc_o          (acc_o),
    .digest_valid_o (digest_valid_o),
    .digest_ready_i (digest_ready_i),
`ifdef MD5_BLKCNT_EN
    .blk_cnt_o      (blk_cnt_o),
`endif
    .busy_o         (busy_o)
  );

  // Clock and watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 400000");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] model(input int i);
    int r;
    int g;
    r = i / 16;
    case (r)
      0:       g = i % 16;
      1:       g = (5 * i + 1) % 16;
      2:       g = (3 * i + 5) % 16;
      default: g = (7 * i) % 16;
    endcase
    return {6'(i), 2'(r), 4'(g), 5'(sh_tab[r * 4 + (i % 4)])};
  endfunction

  // Handshake in the current cycle, then check LOAD, 64 RUN steps and ACC.
  task automatic run_block(input logic last, input logic exp_first, input logic hold_valid);
    logic [16:0] e;
    blk_valid_i = 1'b1;
    blk_last_i  = last;
    chk("ready_before_hs", blk_ready_o, 1);
    tick();
    if (!hold_valid) blk_valid_i = 1'b0;
    blk_last_i = $urandom_range(0, 1);
    chk("iv_load_at_load", iv_load_o, 1);
    chk("first_at_load", first_o, exp_first);
    chk("step_en_at_load", step_en_o, 0);
    chk("ready_at_load", blk_ready_o, 0);
    for (int s = 0; s < 64; s++) exp_q.push_back(model(s));
    for (int s = 0; s < 64; s++) begin
      tick();
      chk("step_en_run", step_en_o, 1);
      chk("ready_run", blk_ready_o, 0);
      obs[step_idx_o] = {step_idx_o, round_o, g_idx_o, shift_o};
      if (exp_q.size() == 0) begin
        chk("scoreboard_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("decode_seq", {15'd0, step_idx_o, round_o, g_idx_o, shift_o}, {15'd0, e});
      end
    end
    tick();
    chk("acc_at_acc", acc_o, 1);
    chk("step_en_at_acc", step_en_o, 0);
    chk("step_idx_at_acc", step_idx_o, 0);
    tick();
    chk("acc_after_acc", acc_o, 0);
    chk("dvalid_after_acc", digest_valid_o, last);
    chk("iv_load_after_acc", iv_load_o, 0);
    if (!last) chk("ready_after_chained", blk_ready_o, 1);
  endtask

  task automatic take_digest(input int hold);
    for (int c = 0; c < hold; c++) begin
      chk("dvalid_hold", digest_valid_o, 1);
      chk("ready_in_out", blk_ready_o, 0);
      chk("busy_in_out", busy_o, 1);
      tick();
    end
    digest_ready_i = 1'b1;
    tick();
    digest_ready_i = 1'b0;
    chk("dvalid_dropped", digest_valid_o, 0);
    chk("ready_after_digest", blk_ready_o, 1);
    chk("busy_after_digest", busy_o, 0);
  endtask

  initial begin
    dtab[0] = '{17, 1, 6, 9};
    dtab[1] = '{37, 2, 4, 11};
    dtab[2] = '{63, 3, 9, 21};
    dtab[3] = '{0, 0, 0, 7};
    dtab[4] = '{5, 0, 5, 12};
    dtab[5] = '{22, 1, 15, 14};
    dtab[6] = '{46, 2, 15, 16};
    dtab[7] = '{51, 3, 5, 21};
    dtab[8] = '{60, 3, 4, 6};

    rst_i = 1'b1;
    blk_valid_i = 1'b0;
    blk_last_i = 1'b0;
    digest_ready_i = 1'b0;
    tick(); tick(); tick();
    rst_i = 1'b0;

    // Reset state
    chk("rst_ready", blk_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_step_en", step_en_o, 0);
    chk("rst_iv_load", iv_load_o, 0);
    chk("rst_acc", acc_o, 0);
    chk("rst_dvalid", digest_valid_o, 0);
    chk("rst_step_idx", step_idx_o, 0);
    chk("rst_g", g_idx_o, 0);
    chk("rst_shift", shift_o, 7);
`ifdef MD5_BLKCNT_EN
    chk("rst_blk_cnt", blk_cnt_o, 0);
`endif

    // Digest-ready outside OUT is ignored
    digest_ready_i = 1'b1;
    tick();
    digest_ready_i = 1'b0;
    chk("idle_ready_ignored", blk_ready_o, 1);
    chk("idle_dvalid", digest_valid_o, 0);

    // Single last block with a 5-cycle digest stall
    run_block(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("dtab_step%0d", dtab[k].step), {15'd0, obs[dtab[k].step]},
          {15'd0, 6'(dtab[k].step), 2'(dtab[k].rnd), 4'(dtab[k].g), 5'(dtab[k].sh)});
    end
    take_digest(5);

    // Two-block message
    run_block(1'b0, 1'b1, 1'b0);
    chk("chained_no_dvalid", digest_valid_o, 0);
    chk("chained_idle", busy_o, 0);
    run_block(1'b1, 1'b0, 1'b0);
    take_digest($urandom_range(0, 3));

    // Reset during step 30 of a chained second block
    run_block(1'b0, 1'b1, 1'b0);
    blk_valid_i = 1'b1;
    blk_last_i = 1'b1;
    tick();
    blk_valid_i = 1'b0;
    chk("second_load_first", first_o, 0);
    for (int c = 0; c < 31; c++) tick();
    chk("at_step30", step_idx_o, 30);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rst_mid_step_en", step_en_o, 0);
    chk("rst_mid_ready", blk_ready_o, 1);
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_step_idx", step_idx_o, 0);
    chk("rst_mid_dvalid", digest_valid_o, 0);
    exp_q.delete();
    run_block(1'b1, 1'b1, 1'b0);
    take_digest(1);

    // Valid held high through RUN and OUT
    run_block(1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 4; c++) begin
      chk("held_no_load", iv_load_o, 0);
      chk("held_dvalid", digest_valid_o, 1);
      tick();
    end
    take_digest(0);
    run_block(1'b1, 1'b1, 1'b0);
    take_digest(2);

`ifdef MD5_BLKCNT_EN
    // Three chained blocks
    run_block(1'b0, 1'b1, 1'b0);
    chk("blk_cnt_1", blk_cnt_o, 1);
    run_block(1'b0, 1'b0, 1'b0);
    run_block(1'b1, 1'b0, 1'b0);
    chk("blk_cnt_3", blk_cnt_o, 3);
    take_digest(1);
    chk("blk_cnt_cleared", blk_cnt_o, 0);
`endif

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
